// File: rtl/clp_inst_issuer_pkg.sv
// Shared constants, CLP instruction field positions and FSM encoding for the CLP instruction issuer.
package clp_inst_issuer_pkg;

    localparam int unsigned CLP_INST_WIDTH  = 100;
    localparam int unsigned CLP_IADDR_W     = 4;
    localparam int unsigned CLP_ACK_TIMEOUT = 15;
    localparam int unsigned CLP_RUN_TIMEOUT = 1023;
    localparam int unsigned CLP_TMO_W       = 10;

    // CLP_ctr instruction word layout
    localparam int unsigned INST_TYPE_LSB        = 0;
    localparam int unsigned INST_TYPE_MSB        = 3;
    localparam int unsigned INST_OUT_ADDR_LSB    = 20;
    localparam int unsigned INST_OUT_ADDR_MSB    = 29;
    localparam int unsigned INST_SCALER_ADDR_LSB = 30;
    localparam int unsigned INST_SCALER_ADDR_MSB = 39;
    localparam int unsigned INST_WGT_AMT_LSB     = 40;
    localparam int unsigned INST_WGT_AMT_MSB     = 54;
    localparam int unsigned INST_WGT_ADDR_LSB    = 55;
    localparam int unsigned INST_WGT_ADDR_MSB    = 69;
    localparam int unsigned INST_FEAT_ADDR_LSB   = 70;
    localparam int unsigned INST_FEAT_ADDR_MSB   = 84;
    localparam int unsigned INST_FEAT_AMT_LSB    = 85;
    localparam int unsigned INST_FEAT_AMT_MSB    = 99;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_WAIT_RUN = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    function automatic logic [3:0] inst_type(input logic [CLP_INST_WIDTH-1:0] inst);
        return inst[INST_TYPE_MSB:INST_TYPE_LSB];
    endfunction

endpackage

// File: rtl/clp_inst_issuer_ram.sv
// Instruction store: 2^AW x DW, one synchronous write port and one registered read port.
module clp_inst_ram
    import clp_inst_issuer_pkg::*;
#(
    parameter int unsigned AW = CLP_IADDR_W,
    parameter int unsigned DW = CLP_INST_WIDTH
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Contents are not reset; a program must be loaded before use.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/clp_inst_issuer.sv
// Issues a stored program of CLP instructions to CLP_ctr over the enable/instruction/state
// handshake, with ACK and RUN timeouts.
module clp_inst_issuer
    import clp_inst_issuer_pkg::*;
#(
    parameter int unsigned INST_WIDTH  = CLP_INST_WIDTH,
    parameter int unsigned IADDR_W     = CLP_IADDR_W,
    parameter int unsigned ACK_TIMEOUT = CLP_ACK_TIMEOUT,
    parameter int unsigned RUN_TIMEOUT = CLP_RUN_TIMEOUT,
    parameter int unsigned TMO_W       = CLP_TMO_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [IADDR_W:0]      i_num_inst,
    input  logic                  i_load_we,
    input  logic [IADDR_W-1:0]    i_load_addr,
    input  logic [INST_WIDTH-1:0] i_load_data,
    input  logic                  i_clp_state,
    output logic                  o_clp_enable,
    output logic [INST_WIDTH-1:0] o_clp_instruction,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout_err,
    output logic [IADDR_W-1:0]    o_pc
);

    localparam int unsigned        NUM_W   = IADDR_W + 1;
    localparam logic [NUM_W-1:0]   NUM_MAX = NUM_W'(2 ** IADDR_W);
    localparam logic [TMO_W-1:0]   ACK_MAX = TMO_W'(ACK_TIMEOUT);
    localparam logic [TMO_W-1:0]   RUN_MAX = TMO_W'(RUN_TIMEOUT);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IADDR_W-1:0]      r_pc;
    logic [IADDR_W-1:0]      w_pc_nxt;
    logic [IADDR_W-1:0]      r_last;
    logic [IADDR_W-1:0]      w_last;
    logic [NUM_W-1:0]        w_num_m1;
    logic [TMO_W-1:0]        r_tmo;
    logic                    w_accept;
    logic                    w_tmo_clr;
    logic                    w_tmo_err;
    logic                    w_ram_we;
    logic [INST_WIDTH-1:0]   w_rdata;
    logic                    r_clp_enable;
    logic [INST_WIDTH-1:0]   r_clp_instruction;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_timeout_err;

    // Read address is the next pc so the word is ready in the cycle before ISSUE.
    clp_inst_ram #(
        .AW (IADDR_W),
        .DW (INST_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_raddr (w_pc_nxt),
        .o_rdata (w_rdata)
    );

    assign w_ram_we = i_load_we && (r_state == S_IDLE);

    // Index of the last instruction, with num_inst saturated to the memory depth.
    assign w_num_m1 = ((i_num_inst > NUM_MAX) ? NUM_MAX : i_num_inst) - NUM_W'(1);
    assign w_last   = IADDR_W'(w_num_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_accept    = 1'b0;
        w_tmo_clr   = 1'b0;
        w_tmo_err   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_pc_nxt    = '0;
                    w_state_nxt = (i_num_inst == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_tmo_clr   = 1'b1;
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (i_clp_state) begin
                    w_tmo_clr   = 1'b1;
                    w_state_nxt = S_WAIT_RUN;
                end else if (r_tmo == ACK_MAX) begin
                    w_tmo_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_RUN: begin
                if (!i_clp_state) begin
                    if (r_pc == r_last) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_pc_nxt    = r_pc + IADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end else if (r_tmo == RUN_MAX) begin
                    w_tmo_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_FINISH: begin
                w_pc_nxt    = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs and counters, all derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc              <= '0;
            r_last            <= '0;
            r_tmo             <= '0;
            r_clp_enable      <= 1'b0;
            r_clp_instruction <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_timeout_err     <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_clp_enable <= (w_state_nxt == S_ISSUE);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_FINISH);
            if (w_state_nxt == S_ISSUE) begin
                r_clp_instruction <= w_rdata;
            end
            if (w_accept) begin
                r_last <= w_last;
            end
            if (w_tmo_clr) begin
                r_tmo <= '0;
            end else if ((r_state == S_WAIT_ACK) || (r_state == S_WAIT_RUN)) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            if (w_accept) begin
                r_timeout_err <= 1'b0;
            end else if (w_tmo_err) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_clp_enable      = r_clp_enable;
    assign o_clp_instruction = r_clp_instruction;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_timeout_err     = r_timeout_err;
    assign o_pc              = r_pc;

endmodule
